// File: rtl/ok_pipe_in_fifo_pkg.sv
// ============================================================================
// Module      : ok_pipe_in_fifo_pkg
// Description : Host-bus field widths, pipe-in address range and lane-width
//               legality helpers shared by the pipe-in endpoint files.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ok_pipe_in_fifo_pkg;

    localparam int          c_BUS_ADDR_W       = 8;
    localparam int          c_BUS_DATA_W       = 32;

    localparam logic [7:0]  c_PIPE_IN_ADDR_MIN = 8'h80;
    localparam logic [7:0]  c_PIPE_IN_ADDR_MAX = 8'h9F;

    localparam int          c_LANE_W_8         = 8;
    localparam int          c_LANE_W_16        = 16;
    localparam int          c_LANE_W_32        = 32;

    function automatic bit is_legal_out_width(input int width);
        return (width == c_LANE_W_8) || (width == c_LANE_W_16) || (width == c_LANE_W_32);
    endfunction

    function automatic bit is_pow2_depth(input int depth);
        return (depth >= 2) && ((depth & (depth - 1)) == 0);
    endfunction

    function automatic bit is_pipe_in_addr(input logic [7:0] addr);
        return (addr >= c_PIPE_IN_ADDR_MIN) && (addr <= c_PIPE_IN_ADDR_MAX);
    endfunction

endpackage

`default_nettype wire

// File: rtl/ok_sync_fifo.sv
// ============================================================================
// Module      : ok_sync_fifo
// Description : Single-clock first-word-fall-through word FIFO with count.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ok_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             ti_clk,
    input  logic             ti_reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_pop_data,
    output logic [AW:0]      o_count,
    output logic             o_full,
    output logic             o_empty
);

    localparam logic [AW:0] c_DEPTH = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    // Full and empty come from the pre-edge count, so a pop never frees room
    // for a push on the same edge.
    assign o_full     = (r_count == c_DEPTH);
    assign o_empty    = (r_count == '0);
    assign o_count    = r_count;
    assign o_pop_data = r_mem[r_rptr];
    assign w_push     = i_push && !o_full;
    assign w_pop      = i_pop  && !o_empty;

    always_ff @(posedge ti_clk) begin
        if (ti_reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + (AW+1)'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge ti_clk) begin
        if (!ti_reset && w_push) begin
            r_mem[r_wptr] <= i_push_data;
        end
    end

endmodule

`default_nettype wire

// File: rtl/ok_pipe_in_fifo.sv
// ============================================================================
// Module      : ok_pipe_in_fifo
// Description : Buffered pipe-in endpoint: address decode, word FIFO, lane
//               serialiser and saturating drop counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ok_pipe_in_fifo
    import ok_pipe_in_fifo_pkg::*;
#(
    parameter logic [7:0] EP_ADDR   = 8'h80,
    parameter int         DEPTH     = 16,
    parameter int         OUT_WIDTH = 32,
    parameter int         AW        = $clog2(DEPTH)
) (
    input  logic                 ti_clk,
    input  logic                 ti_reset,
    input  logic                 ti_write,
    input  logic [7:0]           ti_addr,
    input  logic [31:0]          ti_datain,
    output logic                 ti_ready,
    output logic                 ep_valid,
    input  logic                 ep_read,
    output logic [OUT_WIDTH-1:0] ep_dataout,
    output logic [AW:0]          ep_count,
    output logic                 ep_full,
    output logic [7:0]           ep_overflow
);

    localparam int             RATIO       = c_BUS_DATA_W / OUT_WIDTH;
    localparam int             LW          = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [LW-1:0]  c_LAST_LANE = LW'(RATIO - 1);

    if (!is_legal_out_width(OUT_WIDTH)) begin : g_bad_out_width
        $fatal(1, "ok_pipe_in_fifo: OUT_WIDTH must be 8, 16 or 32");
    end
    if (!is_pow2_depth(DEPTH)) begin : g_bad_depth
        $fatal(1, "ok_pipe_in_fifo: DEPTH must be a power of two >= 2");
    end
    if (!is_pipe_in_addr(EP_ADDR)) begin : g_bad_ep_addr
        $fatal(1, "ok_pipe_in_fifo: EP_ADDR outside pipe-in range");
    end

    logic                 w_hit;
    logic                 w_push;
    logic                 w_drop;
    logic                 w_accept;
    logic                 w_release;
    logic                 w_empty;
    logic [31:0]          w_word;
    logic [OUT_WIDTH-1:0] w_lane_data;
    logic [LW-1:0]        r_lane;
    logic [7:0]           r_overflow;

    assign w_hit     = (ti_addr == EP_ADDR);
    assign ti_ready  = w_hit && !ep_full;
    assign w_push    = ti_write && w_hit && !ep_full;
    assign w_drop    = ti_write && w_hit && ep_full;
    assign ep_valid  = !w_empty;
    assign w_accept  = ep_read && ep_valid;
    assign w_release = w_accept && (r_lane == c_LAST_LANE);

    ok_sync_fifo #(
        .WIDTH (32),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .ti_clk      (ti_clk),
        .ti_reset    (ti_reset),
        .i_push      (w_push),
        .i_push_data (ti_datain),
        .i_pop       (w_release),
        .o_pop_data  (w_word),
        .o_count     (ep_count),
        .o_full      (ep_full),
        .o_empty     (w_empty)
    );

    // Lane 0 occupies the LSBs and is presented first.
    if (RATIO == 1) begin : g_single_lane
        assign w_lane_data = w_word;
    end else begin : g_multi_lane
        assign w_lane_data = w_word[r_lane*OUT_WIDTH +: OUT_WIDTH];
    end

    assign ep_dataout = ep_valid ? w_lane_data : '0;

    always_ff @(posedge ti_clk) begin
        if (ti_reset) begin
            r_lane <= '0;
        end else if (w_accept) begin
            r_lane <= w_release ? '0 : r_lane + LW'(1);
        end
    end

    always_ff @(posedge ti_clk) begin
        if (ti_reset) begin
            r_overflow <= '0;
        end else if (w_drop && (r_overflow != 8'hFF)) begin
            r_overflow <= r_overflow + 8'd1;
        end
    end

    assign ep_overflow = r_overflow;

endmodule

`default_nettype wire
